vram_packetizer: RTL and testbench

Transmit-side counterpart of the receive path that unpacks an 8-bit byte stream into R/G/B VRAM writes. It reads a 24-bit frame buffer one pixel per address and serialises the frame into per-line byte packets. Each packet carries a 4-byte header and R,G,B payload bytes, and is handed to the Ethernet MAC under a valid/ready handshake. It sits between the transmit-side VRAM (read port) and the MAC byte interface, all in the 125 MHz `dclk` domain.

---
 rtl/vram_packetizer.sv | 139 +++++++++++++
 tb/tb_vram_packetizer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_packetizer.sv
// Frame-buffer to MAC packetizer: one packet per line, 4-byte header then R,G,B
// bytes per pixel, with a fixed idle gap after every packet.
module vram_packetizer #(
   parameter int H_PIX   = 320,
   parameter int V_LINES = 240,
   parameter int GAP     = 12,
   parameter int ADDR_W  = 17
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [23:0]       ram_dout,
   input  logic              tx_ready,
   output logic [7:0]        data_out,
   output logic              data_en,
   output logic              busy,
   output logic              done,
   output logic [7:0]        frame_id
);

   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int GW = $clog2(GAP + 1);
   localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
   localparam logic [15:0]   L_LAST = 16'(V_LINES - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

   state_t          state;
   logic [1:0]      hdr_idx;
   logic [1:0]      sub;
   logic [XW-1:0]   pix_x;
   logic [15:0]     line;
   logic [GW-1:0]   gap_cnt;
   logic [15:0]     pix_gb;
   logic            xfer;

   assign xfer = data_en & tx_ready;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state    <= S_IDLE;
         hdr_idx  <= '0;
         sub      <= '0;
         pix_x    <= '0;
         line     <= '0;
         gap_cnt  <= '0;
         pix_gb   <= '0;
         ram_addr <= '0;
         data_out <= '0;
         data_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         frame_id <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // the done cycle is already IDLE, so gate on done to drop that start
               if (start && !done) begin
                  state    <= S_HDR;
                  busy     <= 1'b1;
                  data_en  <= 1'b1;
                  data_out <= 8'hA5;
                  hdr_idx  <= '0;
                  line     <= '0;
                  ram_addr <= '0;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  hdr_idx <= hdr_idx + 2'd1;
                  case (hdr_idx)
                     2'd0:    data_out <= frame_id;
                     2'd1:    data_out <= line[15:8];
                     2'd2:    data_out <= line[7:0];
                     default: begin
                        data_out <= ram_dout[23:16];
                        pix_gb   <= ram_dout[15:0];
                        ram_addr <= ram_addr + ADDR_W'(1);
                        pix_x    <= '0;
                        sub      <= '0;
                        state    <= S_PAY;
                     end
                  endcase
               end
            end
            S_PAY: begin
               if (xfer) begin
                  case (sub)
                     2'd0: begin
                        data_out <= pix_gb[15:8];
                        sub      <= 2'd1;
                     end
                     2'd1: begin
                        data_out <= pix_gb[7:0];
                        sub      <= 2'd2;
                     end
                     default: begin
                        // last pixel: address already points at next line's pixel 0
                        if (pix_x == X_LAST) begin
                           state   <= S_GAP;
                           data_en <= 1'b0;
                           gap_cnt <= '0;
                        end else begin
                           data_out <= ram_dout[23:16];
                           pix_gb   <= ram_dout[15:0];
                           ram_addr <= ram_addr + ADDR_W'(1);
                           pix_x    <= pix_x + XW'(1);
                           sub      <= 2'd0;
                        end
                     end
                  endcase
               end
            end
            default: begin
               if (gap_cnt == G_LAST) begin
                  if (line == L_LAST) begin
                     state    <= S_IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     frame_id <= frame_id + 8'd1;
                  end else begin
                     line     <= line + 16'd1;
                     state    <= S_HDR;
                     data_en  <= 1'b1;
                     data_out <= 8'hA5;
                     hdr_idx  <= '0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_packetizer.sv
// Scoreboard bench for vram_packetizer on a 4x2 frame with GAP=3.
module tb_vram_packetizer;
   localparam int H    = 4;
   localparam int V    = 2;
   localparam int G    = 3;
   localparam int AW   = 4;
   localparam int NPIX = H * V;
   localparam int PKT  = 4 + 3 * H;
   localparam int LINE = PKT + G;
   localparam int DONE_CYC = 1 + V * LINE;

   logic          clk = 1'b0;
   logic          xrst;
   logic          start;
   logic [AW-1:0] ram_addr;
   logic [23:0]   ram_dout;
   logic          tx_ready;
   logic [7:0]    data_out;
   logic          data_en;
   logic          busy;
   logic          done;
   logic [7:0]    frame_id;

   int errors = 0;
   int checks = 0;
   int xfer_cnt = 0;
   int max_addr = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   vram_packetizer #(.H_PIX(H), .V_LINES(V), .GAP(G), .ADDR_W(AW)) dut (
      .clk(clk), .xrst(xrst), .start(start), .ram_addr(ram_addr),
      .ram_dout(ram_dout), .tx_ready(tx_ready), .data_out(data_out),
      .data_en(data_en), .busy(busy), .done(done), .frame_id(frame_id)
   );

   function automatic logic [23:0] word(input logic [AW-1:0] a);
      logic [7:0] n;
      n = 8'(a);
      return {n, n + 8'h10, n + 8'h20};
   endfunction

   always_ff @(posedge clk) ram_dout <= word(ram_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] fid);
      logic [7:0] n;
      for (int l = 0; l < V; l++) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(fid);
         exp_q.push_back(8'(l >> 8));
         exp_q.push_back(8'(l));
         for (int x = 0; x < H; x++) begin
            n = 8'(l * H + x);
            exp_q.push_back(n);
            exp_q.push_back(n + 8'h10);
            exp_q.push_back(n + 8'h20);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs until done (optionally with back-pressure), then moves one cycle past it.
   task automatic run_frame(input bit bp, input int budget);
      int hold;
      int idx;
      hold = 0;
      for (int n = 0; n < budget && !done; n++) begin
         if (bp) begin
            idx = xfer_cnt % PKT;
            if (data_en && (idx == 0 || idx == PKT - 1) && hold < 6) begin
               tx_ready = 1'b0;
               hold++;
            end else begin
               tx_ready = 1'($urandom_range(0, 1));
               if (data_en && idx != 0 && idx != PKT - 1) hold = 0;
            end
         end
         step();
      end
      tx_ready = 1'b1;
      check("frame_timeout", 32'(done), 32'd1);
      step();
   endtask

   // Byte scoreboard plus stall-hold and address-step monitoring.
   initial begin
      bit         prev_stall;
      bit         prev_ok;
      logic [7:0] prev_dout;
      logic [AW-1:0] prev_addr;
      logic [7:0] e;
      prev_stall = 1'b0;
      prev_ok    = 1'b0;
      prev_dout  = '0;
      prev_addr  = '0;
      forever begin
         @(negedge clk);
         if (xrst !== 1'b1) begin
            prev_stall = 1'b0;
            prev_ok    = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_hold", 32'({data_en, data_out}), 32'({1'b1, prev_dout}));
               check("stall_addr", 32'(ram_addr), 32'(prev_addr));
            end
            if (prev_ok && ram_addr != prev_addr && ram_addr != '0)
               check("addr_step", 32'(ram_addr), 32'(prev_addr) + 32'd1);
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (data_en && tx_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_xfer", 32'(data_en), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("byte", 32'(data_out), 32'(e));
                  xfer_cnt++;
               end
            end
            prev_stall = data_en && !tx_ready;
            prev_dout  = data_out;
            prev_addr  = ram_addr;
            prev_ok    = 1'b1;
         end
      end
   end

   initial begin
      int ph;
      xrst = 1'b0;
      start = 1'b0;
      tx_ready = 1'b1;
      step();
      check("rst_data_en", 32'(data_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_frame_id", 32'(frame_id), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      xrst = 1'b1;
      step();

      // basic frame, cycle-accurate timing
      push_frame(8'h00);
      pulse_start();
      check("c1_data_out", 32'(data_out), 32'hA5);
      for (int c = 1; c <= DONE_CYC; c++) begin
         ph = (c - 1) % LINE;
         check("basic_busy", 32'(busy), (c < DONE_CYC) ? 32'd1 : 32'd0);
         check("basic_done", 32'(done), (c == DONE_CYC) ? 32'd1 : 32'd0);
         check("basic_en", 32'(data_en), (c < DONE_CYC && ph < PKT) ? 32'd1 : 32'd0);
         if (c < DONE_CYC) step();
      end
      check("basic_fid", 32'(frame_id), 32'd1);
      check("basic_final_addr", 32'(ram_addr), 32'(NPIX));
      check("basic_drain", 32'(exp_q.size()), 32'd0);
      step();

      // back-pressure with forced stalls on header byte 0 and last B
      push_frame(8'h01);
      pulse_start();
      run_frame(1'b1, 2000);
      check("bp_fid", 32'(frame_id), 32'd2);
      check("bp_drain", 32'(exp_q.size()), 32'd0);

      // start pulses in HDR, PAY, GAP and the done cycle are dropped
      push_frame(8'h02);
      pulse_start();
      for (int c = 1; c <= DONE_CYC; c++) begin
         start = (c == 2 || c == 8 || c == 18 || c == DONE_CYC);
         if (c == DONE_CYC) check("sh_done", 32'(done), 32'd1);
         step();
      end
      start = 1'b0;
      check("sh_idle_after_done", 32'(busy), 32'd0);
      check("sh_drain", 32'(exp_q.size()), 32'd0);
      push_frame(8'h03);
      pulse_start();
      check("sh_restart_busy", 32'(busy), 32'd1);
      run_frame(1'b0, 200);
      check("sh_fid", 32'(frame_id), 32'd4);

      // asynchronous reset during PAY of line 1
      push_frame(8'h04);
      pulse_start();
      for (int c = 1; c < LINE + 6; c++) step();
      check("pre_rst_pay", 32'(data_en), 32'd1);
      #2;
      xrst = 1'b0;
      exp_q.delete();
      xfer_cnt = 0;
      #1;
      check("arst_data_en", 32'(data_en), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_frame_id", 32'(frame_id), 32'd0);
      check("arst_ram_addr", 32'(ram_addr), 32'd0);
      check("arst_data_out", 32'(data_out), 32'd0);
      step();
      xrst = 1'b1;
      step();
      check("post_rst_idle", 32'(data_en), 32'd0);
      push_frame(8'h00);
      pulse_start();
      check("post_rst_addr", 32'(ram_addr), 32'd0);
      check("post_rst_hdr", 32'(data_out), 32'hA5);
      run_frame(1'b0, 200);
      check("post_rst_fid", 32'(frame_id), 32'd1);

      // frame_id wrap: frames 2..256 since reset carry ids 01..FF
      for (int f = 1; f < 256; f++) begin
         push_frame(8'(f));
         pulse_start();
         run_frame(1'b0, 200);
      end
      check("wrap_fid", 32'(frame_id), 32'd0);
      push_frame(8'h00);
      pulse_start();
      run_frame(1'b0, 200);
      check("wrap_next_fid", 32'(frame_id), 32'd1);

      check("final_drain", 32'(exp_q.size()), 32'd0);
      check("max_addr", 32'(max_addr), 32'(NPIX));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
